// File: rtl/gups_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between GUPS engines; holds the
// grant across a full read-modify-write and counts completed updates.
module gups_mem_arbiter #(
  parameter int unsigned N_ENG = 4,
  parameter int unsigned AW    = 64,
  parameter int unsigned DW    = 64,
  parameter int unsigned CW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [N_ENG-1:0]    eng_req,
  input  logic [N_ENG-1:0]    eng_wr,
  input  logic [N_ENG*AW-1:0] eng_addr,
  input  logic [N_ENG*DW-1:0] eng_wdata,
  output logic [DW-1:0]       eng_rdata,
  output logic [N_ENG-1:0]    eng_ready,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata,
  input  logic                mem_ready,
  output logic [N_ENG-1:0]    grant,
  output logic                busy,
  output logic [CW-1:0]       update_count
);

  localparam int unsigned IW = (N_ENG > 1) ? $clog2(N_ENG) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT_WR, S_WR, S_REL} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_rr;
  logic [IW-1:0]    r_gidx;

  logic [N_ENG-1:0] w_cand;
  logic             w_found;
  logic [IW-1:0]    w_pick;
  logic [IW-1:0]    w_rr_next;
  logic             w_greq;
  logic             w_gwr;
  int unsigned      w_idx;

  // First read-phase requester scanning upward from the round-robin pointer.
  always_comb begin
    w_cand  = eng_req & ~eng_wr;
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < N_ENG; k++) begin
      w_idx = (32'(r_rr) + k) % N_ENG;
      if (!w_found && w_cand[IW'(w_idx)]) begin
        w_found = 1'b1;
        w_pick  = IW'(w_idx);
      end
    end
  end

  assign w_greq    = eng_req[r_gidx];
  assign w_gwr     = eng_wr[r_gidx];
  assign w_rr_next = (32'(r_gidx) == N_ENG - 1) ? '0 : r_gidx + IW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rr         <= '0;
      r_gidx       <= '0;
      mem_req      <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      eng_rdata    <= '0;
      eng_ready    <= '0;
      grant        <= '0;
      busy         <= 1'b0;
      update_count <= '0;
    end else begin
      eng_ready <= '0;
      case (r_state)
        S_IDLE: begin
          if (enable && w_found) begin
            grant    <= {{(N_ENG-1){1'b0}}, 1'b1} << w_pick;
            r_gidx   <= w_pick;
            mem_addr <= eng_addr[32'(w_pick)*AW +: AW];
            mem_req  <= 1'b1;
            mem_wr   <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_RD;
          end
        end
        S_RD: begin
          if (mem_ready) begin
            eng_rdata <= mem_rdata;
            eng_ready <= grant;
            mem_req   <= 1'b0;
            r_state   <= S_WAIT_WR;
          end
        end
        S_WAIT_WR: begin
          // A dropped request here means the engine abandoned the update.
          if (!w_greq) begin
            grant   <= '0;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_gwr) begin
            mem_wdata <= eng_wdata[32'(r_gidx)*DW +: DW];
            mem_req   <= 1'b1;
            mem_wr    <= 1'b1;
            r_state   <= S_WR;
          end
        end
        S_WR: begin
          if (mem_ready) begin
            eng_ready    <= grant;
            mem_req      <= 1'b0;
            mem_wr       <= 1'b0;
            update_count <= update_count + CW'(1);
            r_state      <= S_REL;
          end
        end
        S_REL: begin
          // Wait for the stale request to clear so it is not re-granted.
          if (!w_greq) begin
            r_rr    <= w_rr_next;
            grant   <= '0;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gups_mem_arbiter.sv
// Directed bench for gups_mem_arbiter: inputs change and outputs are checked
// on the falling clock edge.
module tb_gups_mem_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [N-1:0]    eng_req;
  logic [N-1:0]    eng_wr;
  logic [N*AW-1:0] eng_addr;
  logic [N*DW-1:0] eng_wdata;
  logic [DW-1:0]   eng_rdata;
  logic [N-1:0]    eng_ready;
  logic            mem_req;
  logic            mem_wr;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ready;
  logic [N-1:0]    grant;
  logic            busy;
  logic [CW-1:0]   update_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  gups_mem_arbiter #(.N_ENG(N), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .eng_req(eng_req), .eng_wr(eng_wr), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_rdata(eng_rdata), .eng_ready(eng_ready),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .busy(busy), .update_count(update_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    exp_cnt = 0;
  endtask

  // Request from engine e and complete the read phase; ends in WAIT_WR.
  task automatic do_read(input int e, input logic [63:0] addr, input logic [63:0] rdata,
                         input int stall);
    logic [N-1:0] g;
    g = N'(1) << e;
    eng_addr[e*AW +: AW] = addr;
    eng_req[e] = 1'b1;
    eng_wr[e]  = 1'b0;
    step();
    chk("rd_req", 64'(mem_req), 64'd1);
    chk("rd_wr", 64'(mem_wr), 64'd0);
    chk("rd_addr", mem_addr, addr);
    chk("rd_grant", 64'(grant), 64'(g));
    chk("rd_busy", 64'(busy), 64'd1);
    for (int s = 0; s < stall; s++) begin
      step();
      chk("stall_req", 64'(mem_req), 64'd1);
      chk("stall_addr", mem_addr, addr);
      chk("stall_grant", 64'(grant), 64'(g));
      chk("stall_ready", 64'(eng_ready), 64'd0);
    end
    mem_rdata = rdata;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("rack_ready", 64'(eng_ready), 64'(g));
    chk("rack_rdata", eng_rdata, rdata);
    chk("rack_req", 64'(mem_req), 64'd0);
  endtask

  // Write phase and release; ends back in IDLE.
  task automatic do_write(input int e, input logic [63:0] addr, input logic [63:0] wdata);
    logic [N-1:0] g;
    g = N'(1) << e;
    eng_wdata[e*DW +: DW] = wdata;
    eng_wr[e] = 1'b1;
    step();
    chk("wr_req", 64'(mem_req), 64'd1);
    chk("wr_wr", 64'(mem_wr), 64'd1);
    chk("wr_addr", mem_addr, addr);
    chk("wr_data", mem_wdata, wdata);
    chk("wr_grant", 64'(grant), 64'(g));
    chk("wr_ready_lo", 64'(eng_ready), 64'd0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    exp_cnt++;
    chk("wack_ready", 64'(eng_ready), 64'(g));
    chk("wack_req", 64'(mem_req), 64'd0);
    chk("wack_count", 64'(update_count), 64'(exp_cnt));
    eng_req[e] = 1'b0;
    eng_wr[e]  = 1'b0;
    step();
    chk("rel_grant", 64'(grant), 64'd0);
    chk("rel_busy", 64'(busy), 64'd0);
    chk("rel_ready", 64'(eng_ready), 64'd0);
  endtask

  task automatic do_update(input int e, input logic [63:0] addr, input logic [63:0] rdata,
                           input logic [63:0] wdata, input int stall);
    do_read(e, addr, rdata, stall);
    do_write(e, addr, wdata);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; eng_req = '0; eng_wr = '0;
    eng_addr = '0; eng_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    #2;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(update_count), 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    do_reset();

    // Single engine read-modify-write.
    do_update(0, 64'h40, 64'h7, 64'h8, 0);

    // Stray mem_ready while idle is ignored.
    mem_ready = 1'b1; step(); mem_ready = 1'b0;
    chk("idle_ack_ready", 64'(eng_ready), 64'd0);
    chk("idle_ack_busy", 64'(busy), 64'd0);
    chk("idle_ack_count", 64'(update_count), 64'd1);

    // All four request together after reset: served 0,1,2,3.
    do_reset();
    for (int i = 0; i < 4; i++) eng_addr[i*AW +: AW] = 64'h1000 + 64'(i) * 64'h100;
    eng_req = 4'hF;
    for (int i = 0; i < 4; i++)
      do_update(i, 64'h1000 + 64'(i) * 64'h100, 64'hA0 + 64'(i), 64'hB0 + 64'(i), i);
    chk("all4_count", 64'(update_count), 64'd4);

    // Engine 2 then engines 1 and 2 together: order 2,1,2.
    do_update(2, 64'h2200, 64'h11, 64'h12, 0);
    eng_addr[2*AW +: AW] = 64'h2201;
    eng_req[2] = 1'b1;
    eng_req[1] = 1'b1;
    do_update(1, 64'h2100, 64'h21, 64'h22, 0);
    do_update(2, 64'h2201, 64'h31, 64'h32, 0);
    chk("rr_count", 64'(update_count), 64'd7);

    // Ten-cycle read stall.
    do_update(0, 64'h3000, 64'hDEAD, 64'hBEEF, 10);

    // Requester already in write phase while idle is ignored.
    eng_req[1] = 1'b1; eng_wr[1] = 1'b1;
    step(); step();
    chk("proto_busy", 64'(busy), 64'd0);
    chk("proto_grant", 64'(grant), 64'd0);
    eng_req[1] = 1'b0; eng_wr[1] = 1'b0;

    // Engine abandons the update in WAIT_WR.
    do_read(1, 64'h4100, 64'h55, 0);
    eng_req[1] = 1'b0;
    step();
    chk("abort_grant", 64'(grant), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_memreq", 64'(mem_req), 64'd0);
    chk("abort_count", 64'(update_count), 64'(exp_cnt));

    // enable drops in WAIT_WR: update finishes, then no new grant.
    do_read(3, 64'h5300, 64'h66, 0);
    enable = 1'b0;
    do_write(3, 64'h5300, 64'h67);
    chk("en_count", 64'(update_count), 64'd9);
    for (int i = 0; i < 4; i++) eng_addr[i*AW +: AW] = 64'h6000 + 64'(i);
    eng_req = 4'hF; eng_wr = 4'h0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("en_off_grant", 64'(grant), 64'd0);
      chk("en_off_req", 64'(mem_req), 64'd0);
    end
    enable = 1'b1;
    step();
    chk("en_on_grant", 64'(grant), 64'h1);
    chk("en_on_addr", mem_addr, 64'h6000);

    // Asynchronous reset in the middle of WR.
    mem_rdata = 64'h77; mem_ready = 1'b1; step(); mem_ready = 1'b0;
    eng_wdata[0 +: DW] = 64'h78; eng_wr[0] = 1'b1;
    step();
    chk("pre_rst_wr", 64'(mem_wr), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_req", 64'(mem_req), 64'd0);
    chk("arst_wr", 64'(mem_wr), 64'd0);
    chk("arst_addr", mem_addr, 64'd0);
    chk("arst_wdata", mem_wdata, 64'd0);
    chk("arst_rdata", eng_rdata, 64'd0);
    chk("arst_grant", 64'(grant), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_count", 64'(update_count), 64'd0);
    step();
    reset = 1'b1;
    eng_wr = 4'h0;
    step();
    chk("post_rst_grant", 64'(grant), 64'h1);
    chk("post_rst_addr", mem_addr, 64'h6000);
    chk("post_rst_count", 64'(update_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gups_mem_arbiter.md
Name: gups_mem_arbiter

Overview:
- Shares one memory port between N_ENG gups engines, using round-robin arbitration.
- Each engine issues one read-modify-write update at a time: req high, read, then wr high, then write.
- The arbiter holds a grant for one whole update, so read and write of one address are never split by another engine.
- It also counts completed updates for GUPS rate measurement.

Parameters:
- N_ENG, 4, number of engines (2..16).
- AW, 64, address width.
- DW, 64, data width.
- CW, 32, width of the update counter.

Ports:
- clk  in  1  system clock, 200 MHz.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  when 0, no new grant is issued; an update in flight completes normally.
- eng_req  in  N_ENG  per-engine request level.
- eng_wr  in  N_ENG  per-engine write phase flag.
- eng_addr  in  N_ENG*AW  packed addresses; engine i uses bits [i*AW +: AW].
- eng_wdata  in  N_ENG*DW  packed write data.
- eng_rdata  out  DW  read data, broadcast to all engines.
- eng_ready  out  N_ENG  per-engine one-cycle completion pulse.
- mem_req  out  1  memory request, held until mem_ready.
- mem_wr  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  read data, valid when mem_ready is high on a read.
- mem_ready  in  1  one-cycle completion pulse from memory.
- grant  out  N_ENG  one-hot owner of the port; all zero when idle.
- busy  out  1  high when the FSM is not in IDLE.
- update_count  out  CW  number of completed updates.

Behaviour:
- Reset (reset=0, asynchronous), all outputs and registers to zero:
  - mem_req, mem_wr, mem_addr, mem_wdata.
  - eng_rdata, eng_ready, grant, busy, update_count.
  - Round-robin pointer rr=0; FSM state = IDLE.
- Address and write data are registered when sampled.
- mem_addr and mem_wdata are driven from those registers, never straight from the engine inputs.
- IDLE:
  - A candidate is engine i with eng_req[i]=1 and eng_wr[i]=0.
  - If enable=1 and a candidate exists, pick the first candidate scanning from rr upward, modulo N_ENG.
  - Register grant, latch that engine's address, set mem_req=1 and mem_wr=0, go to RD.
  - The first mem_req occurs the cycle after the request is sampled (1-cycle arbitration latency).
- RD (mem_req=1, mem_wr=0):
  - On mem_ready: eng_rdata <= mem_rdata; eng_ready[g] pulses for exactly one cycle; mem_req <= 0; go to WAIT_WR.
- WAIT_WR:
  - When eng_wr[g]=1: latch eng_wdata[g]; set mem_req=1 and mem_wr=1; go to WR.
  - If eng_req[g] drops in this state (engine reset), set grant <= 0 and go to IDLE. No write is issued and the count is not incremented.
- WR (mem_req=1, mem_wr=1):
  - On mem_ready: eng_ready[g] pulses for one cycle; mem_req <= 0; mem_wr <= 0; update_count increments; go to REL.
  - update_count wraps modulo 2^CW.
- REL:
  - Wait for eng_req[g]=0; the engine drops req the cycle after the write ack.
  - Then set rr <= (g+1) mod N_ENG, grant <= 0, go to IDLE.
  - This prevents the finished engine's stale req from being re-granted.
- General rules:
  - mem_ready outside RD or WR is ignored.
  - eng_ready is never high for a non-granted engine.
  - At most one eng_ready bit is high in any cycle.
  - mem_req never drops before mem_ready is seen.
- Simultaneous requests: the fixed rr scan decides. After engine g completes, the next winner is the lowest-distance requester above g.
- enable deasserted mid-update: the current update finishes (RD → WAIT_WR → WR → REL). The FSM then stays in IDLE until enable=1.
- A requester with eng_wr=1 in IDLE (protocol error) is not a candidate and is ignored.

Test Plan:
- Single engine: eng_req[0]=1 with addr 0x40; mem returns 0x7 on the read. Required: mem_req on the next cycle with mem_wr=0 and mem_addr=0x40; eng_ready[0] pulses with eng_rdata=0x7; engine asserts wr with data 0x8; mem write of 0x8 to 0x40; update_count=1; grant returns to 0.
- All four engines request at once after reset (rr=0): grants are issued in order 0,1,2,3, each holding the port through both its read and its write; update_count=4; the two phases of any one update are never interleaved with another engine.
- Engine 2 requests continuously while engine 1 issues one request after engine 2's first update: the grant order is 2,1,2, so the finished engine does not win twice in a row while another is waiting.
- Memory stalls mem_ready for 10 cycles on the read: mem_req, mem_addr and grant stay stable; no eng_ready pulse occurs before mem_ready.
- enable drops in WAIT_WR: the write completes and update_count increments; no new grant is issued until enable=1 again, even with eng_req all ones.
- reset pulled low while in WR: all outputs are zero immediately (asynchronous); after release the arbiter starts in IDLE with rr=0 and update_count=0.
